// File: rtl/div_sequencer.sv
// Multi-cycle 32-bit integer divider for DIV/DIVU/REM/REMU: one restoring step per
// cycle, with the divide-by-zero and signed-overflow cases answered without iterating.
module div_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

    state_t      state, state_next;
    logic [4:0]  count;
    logic        op_unsigned;
    logic        op_rem;
    logic        q_neg;
    logic        r_neg;
    logic [31:0] quo;       // dividend bits shift out the top, quotient bits shift in below
    logic [31:0] divisor;
    logic [31:0] rem;

    // Only DIV-family encodings reach this block, so funct3[2] carries no information.
    logic unused_funct3;
    assign unused_funct3 = funct3[2];

    logic        signed_in;
    logic [31:0] abs_rs1;
    logic [31:0] abs_rs2;
    logic        div_zero;
    logic        overflow;
    logic [31:0] special_result;

    assign signed_in = ~funct3[0];
    assign abs_rs1   = (signed_in && rs1[31]) ? -rs1 : rs1;
    assign abs_rs2   = (signed_in && rs2[31]) ? -rs2 : rs2;
    assign div_zero  = (rs2 == 32'd0);
    assign overflow  = signed_in && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

    always_comb begin
        special_result = 32'd0;
        if (div_zero)
            special_result = funct3[1] ? rs1 : 32'hFFFF_FFFF;
        else if (overflow)
            special_result = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign rem_shift = {rem, quo[31]};
    assign diff      = rem_shift - {1'b0, divisor};
    assign q_fix     = (!op_unsigned && q_neg) ? -quo : quo;
    assign r_fix     = (!op_unsigned && r_neg) ? -rem : rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every path through a combinational block starts from a default so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = (div_zero || overflow) ? DONE : ITER;
            ITER:    if (count == 5'd31) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= 5'd0;
            op_unsigned <= 1'b0;
            op_rem      <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quo         <= 32'd0;
            divisor     <= 32'd0;
            rem         <= 32'd0;
            result      <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !flush) begin
                        op_unsigned <= funct3[0];
                        op_rem      <= funct3[1];
                        q_neg       <= rs1[31] ^ rs2[31];
                        r_neg       <= rs1[31];
                        quo         <= abs_rs1;
                        divisor     <= abs_rs2;
                        rem         <= 32'd0;
                        count       <= 5'd0;
                        if (div_zero || overflow)
                            result <= special_result;
                    end
                end
                ITER: begin
                    // A negative difference means the divisor did not fit: keep the shifted value.
                    rem   <= diff[32] ? rem_shift[31:0] : diff[31:0];
                    quo   <= {quo[30:0], ~diff[32]};
                    count <= count + 5'd1;
                end
                FIXUP: begin
                    if (!flush)
                        result <= op_rem ? r_fix : q_fix;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign stall = ((state == IDLE) && start) || (state == ITER) || (state == FIXUP);

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameters: none; the datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single system clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin a divide; sampled only in IDLE.
REQ-005 funct3  input  3  operation select: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1  input  32  dividend.
REQ-007 rs2  input  32  divisor.
REQ-008 flush  input  1  synchronous abort of the operation in flight.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 stall  output  1  pipeline hold request.
REQ-011 done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-012 result  output  32  quotient or remainder, registered.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, ITER, FIXUP and DONE.
REQ-014 Operand capture:
- In IDLE with start=1, the block SHALL latch funct3.
- It SHALL latch |rs1| and |rs2| when signed (funct3[0]=0), otherwise the raw values.
- It SHALL latch quotient sign (rs1[31]^rs2[31]) and remainder sign (rs1[31]).
- Then: special case -> DONE; otherwise -> ITER with counter=0, partial remainder=0.
REQ-015 Divide-by-zero special case (rs2=0):
- DIV/DIVU result SHALL be 32'hFFFF_FFFF.
- REM/REMU result SHALL be rs1.
REQ-016 Signed-overflow special case (DIV/REM, rs1=32'h8000_0000, rs2=32'hFFFF_FFFF):
- DIV result SHALL be 32'h8000_0000.
- REM result SHALL be 0.
REQ-017 ITER, one restoring step per cycle, MSB of dividend first:
- Shift the next dividend bit into the 33-bit partial remainder.
- Subtract the divisor; if the difference is non-negative, keep it and set the quotient bit, else restore.
REQ-018 ITER SHALL last exactly 32 cycles (counter 0..31); after the cycle with counter=31 the FSM SHALL enter FIXUP.
REQ-019 FIXUP:
- Signed ops: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
- Select the quotient (funct3[1]=0) or remainder (funct3[1]=1) into result.
- Go to DONE.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE; start in DONE SHALL be ignored.
REQ-021 Latency: done SHALL be high 34 cycles after the start-sampling edge for normal ops, and 1 cycle after it for special cases.
REQ-022 result SHALL hold its value from DONE until the next DONE; it SHALL NOT change during ITER or FIXUP.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 stall SHALL equal (IDLE & start) | ITER | FIXUP, combinationally, so a requesting instruction holds until its done cycle.
REQ-025 flush=1 in any state SHALL force IDLE at the next edge with no done pulse and result unchanged; flush has priority over start.
REQ-026 Unsigned ops SHALL ignore operand sign bits entirely; rs2=1 SHALL produce quotient=rs1, remainder=0.

Reset
REQ-027 While rst=1, asynchronously: state=IDLE, counter=0, result=0, busy=0, done=0.
REQ-028 Reset mid-operation SHALL abandon the divide; no done pulse SHALL follow the reset release.
REQ-029 The first start after reset release SHALL be accepted on the first rising edge.

Verification
REQ-030 DIV rs1=-7 (32'hFFFF_FFF9), rs2=2 -> done after 34 cycles, result=32'hFFFF_FFFD (-3); REM with the same operands -> result=32'hFFFF_FFFF (-1).
REQ-031 DIVU rs1=32'hFFFF_FFFF, rs2=16 -> result=32'h0FFF_FFFF; REMU with the same operands -> result=15.
REQ-032 DIV rs2=0 -> done 1 cycle after start, result=32'hFFFF_FFFF; REM rs1=123, rs2=0 -> result=123.
REQ-033 DIV rs1=32'h8000_0000, rs2=-1 -> result=32'h8000_0000, 1-cycle latency; REM with the same operands -> result=0.
REQ-034 Overlap and abort:
- start re-pulsed at cycle 10 of an op -> ignored, single done.
- flush at cycle 20 -> IDLE, no done, prior result kept.
REQ-035 rst asserted mid-ITER -> busy=0, result=0 immediately; random 10k-op compare against the RISC-V reference model for all four funct3 codes.
